// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked 16-op ALU with registered result and iterative restoring divider
// Optional feature macro: ALU_SAT_EN (saturating add/sub).
module alu_pipe #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [3:0]       s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   y,
    output logic             zero,
    output logic             dz
);

    typedef enum logic {
        S_IDLE,
        S_DIV
    } state_t;

    localparam int              CW       = $clog2(W);
    localparam logic [CW-1:0]   CNT_INIT = CW'(W - 1);
    localparam logic [W-1:0]    W_L      = W'(W);
    localparam logic [W:0]      W2_L     = (W + 1)'(2 * W);
    localparam logic [2*W-1:0]  LOW_ONES = {{W{1'b0}}, {W{1'b1}}};

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [W-1:0]    dsr_q, dsr_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            mod_q, mod_d;

    logic            ov_q, ov_d;
    logic [2*W-1:0]  y_q, y_d;
    logic            zero_q, zero_d;
    logic            dz_q, dz_d;

    logic            accept;
    logic            out_xfer;
    logic            start_div;
    logic            div_last;

    logic [2*W-1:0]  ax, bx, sum, dif;
    logic [2*W-1:0]  res;
    logic            res_dz;

    logic [W:0]      trial;
    logic [W:0]      rem_nx;
    logic            qbit;
    logic [W-1:0]    quo_nx;
    logic [2*W-1:0]  div_res;

    assign in_ready  = (state_q == S_IDLE) & (~ov_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_xfer  = ov_q & out_ready;
    assign start_div = accept & ((s == 4'd3) | (s == 4'd4)) & (b != '0);
    assign div_last  = (state_q == S_DIV) & (cnt_q == '0);

    // Single-cycle op results; div/mod here only cover the b==0 case.
    assign ax  = {{W{1'b0}}, a};
    assign bx  = {{W{1'b0}}, b};
    assign sum = ax + bx;
    assign dif = ax - bx;

    always_comb begin
        res    = '0;
        res_dz = 1'b0;
        case (s)
            4'd0: begin
                res = sum;
`ifdef ALU_SAT_EN
                if (sum[W]) res = LOW_ONES;
`endif
            end
            4'd1: begin
                res = dif;
`ifdef ALU_SAT_EN
                if (b > a) res = '0;
`endif
            end
            4'd2:  res = ax * bx;
            4'd3: begin
                res    = LOW_ONES;
                res_dz = 1'b1;
            end
            4'd4: begin
                res    = ax;
                res_dz = 1'b1;
            end
            4'd5:  res = ax & bx;
            4'd6:  res = ax | bx;
            4'd7:  res = {{(2*W-1){1'b0}}, (a == b)};
            4'd8:  res = {{(2*W-1){1'b0}}, ((a != '0) && (b != '0))};
            4'd9:  res = {{(2*W-1){1'b0}}, ((a != '0) || (b != '0))};
            4'd10: res = (b >= W_L) ? '0 : (ax >> b);
            4'd11: res = ({1'b0, b} >= W2_L) ? '0 : (ax << b);
            4'd12: res = ax ^ bx;
            4'd13: res = {{W{1'b0}}, ~a};
            4'd14: res = {a, b};
            4'd15: res = {a, a};
            default: res = '0;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign trial   = {rem_q, dvd_q[W-1]};
    assign qbit    = (trial >= {1'b0, dsr_q});
    assign rem_nx  = qbit ? (trial - {1'b0, dsr_q}) : trial;
    assign quo_nx  = {quo_q[W-2:0], qbit};
    assign div_res = mod_q ? {{W{1'b0}}, rem_nx[W-1:0]} : {{W{1'b0}}, quo_nx};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        mod_d   = mod_q;
        ov_d    = ov_q;
        y_d     = y_q;
        zero_d  = zero_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start_div) begin
                    state_d = S_DIV;
                    cnt_d   = CNT_INIT;
                    dvd_d   = a;
                    dsr_d   = b;
                    quo_d   = '0;
                    rem_d   = '0;
                    mod_d   = (s == 4'd4);
                end
            end
            S_DIV: begin
                dvd_d = {dvd_q[W-2:0], 1'b0};
                rem_d = rem_nx[W-1:0];
                quo_d = quo_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (out_xfer) ov_d = 1'b0;

        // A new result wins over the clear so back-to-back transfers keep full rate.
        if (accept && !start_div) begin
            ov_d   = 1'b1;
            y_d    = res;
            zero_d = (res == '0);
            dz_d   = res_dz;
        end else if (div_last) begin
            ov_d   = 1'b1;
            y_d    = div_res;
            zero_d = (div_res == '0);
            dz_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            mod_q   <= 1'b0;
            ov_q    <= 1'b0;
            y_q     <= '0;
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            mod_q   <= mod_d;
            ov_q    <= ov_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
        end
    end

    assign out_valid = ov_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe against a queue-based reference model
module tb_alu_pipe;

    localparam int W  = 4;
    localparam int YW = 2 * W;
    localparam int M  = (1 << YW) - 1;
    localparam int LW = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    s;
    logic          out_valid;
    logic          out_ready;
    logic [YW-1:0] y;
    logic          zero;
    logic          dz;

    always #5 clk = ~clk;

    alu_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .dz        (dz)
    );

    typedef struct {
        int y;
        bit dz;
        int vis;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int ref_y(input int op, input int av, input int bv, output bit rdz);
        int r;
        rdz = 1'b0;
        case (op)
            0: begin
                r = av + bv;
`ifdef ALU_SAT_EN
                if (r > LW) r = LW;
`endif
            end
            1: begin
                r = (av - bv) & M;
`ifdef ALU_SAT_EN
                if (bv > av) r = 0;
`endif
            end
            2:  r = av * bv;
            3:  begin if (bv == 0) begin r = LW; rdz = 1'b1; end else r = av / bv; end
            4:  begin if (bv == 0) begin r = av; rdz = 1'b1; end else r = av % bv; end
            5:  r = av & bv;
            6:  r = av | bv;
            7:  r = (av == bv) ? 1 : 0;
            8:  r = (av != 0 && bv != 0) ? 1 : 0;
            9:  r = (av != 0 || bv != 0) ? 1 : 0;
            10: r = (bv >= W) ? 0 : (av >> bv);
            11: r = (bv >= 2 * W) ? 0 : ((av << bv) & M);
            12: r = av ^ bv;
            13: r = (~av) & LW;
            14: r = av * (1 << W) + bv;
            default: r = av * (1 << W) + av;
        endcase
        return r;
    endfunction

    // One clock: drive inputs at negedge, compare outputs against the model, update the model.
    task automatic step(input bit iv, input int av, input int bv, input int op, input bit ordy);
        bit   exp_ov, exp_ir, pend, rdz;
        exp_t e;
        @(negedge clk);
        cyc++;
        in_valid  = iv;
        a         = W'(av);
        b         = W'(bv);
        s         = 4'(op);
        out_ready = ordy;
        #1;
        exp_ov = (q.size() > 0) && (cyc >= q[0].vis);
        pend   = (q.size() > 0) && (cyc < q[q.size()-1].vis);
        exp_ir = !pend && (!exp_ov || ordy);
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        if (exp_ov) begin
            check_eq("y", 32'(y), q[0].y);
            check_eq("zero", {31'd0, zero}, (q[0].y == 0) ? 1 : 0);
            check_eq("dz", {31'd0, dz}, {31'd0, q[0].dz});
            if (ordy) void'(q.pop_front());
        end
        if (iv && exp_ir) begin
            e.y   = ref_y(op, av, bv, rdz);
            e.dz  = rdz;
            e.vis = cyc + (((op == 3 || op == 4) && bv != 0) ? W + 1 : 1);
            q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 0);
        check_eq("rst_y", 32'(y), 0);
        check_eq("rst_zero", {31'd0, zero}, 0);
        check_eq("rst_dz", {31'd0, dz}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 1);
        q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int av, bv, op;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        s         = '0;
        do_reset();

        // Add with carry into bit W
        step(1, 15, 1, 0, 1);
        step(0, 0, 0, 0, 1);
`ifdef ALU_SAT_EN
        check_eq("t1_y", 32'(y), 32'h0F);
`else
        check_eq("t1_y", 32'(y), 32'h10);
`endif
        check_eq("t1_zero", {31'd0, zero}, 0);

        // Subtract going negative
        step(1, 3, 5, 1, 1);
        step(0, 0, 0, 0, 1);
`ifdef ALU_SAT_EN
        check_eq("t2_y", 32'(y), 32'h00);
        check_eq("t2_zero", {31'd0, zero}, 1);
`else
        check_eq("t2_y", 32'(y), 32'hFE);
        check_eq("t2_zero", {31'd0, zero}, 0);
`endif

        // Divide then modulo: busy for W cycles, result on the (W+1)th
        step(1, 13, 4, 3, 1);
        for (int i = 0; i < W; i++) begin
            step(1, 13, 4, 4, 1);
            check_eq("t3_busy", {31'd0, in_ready}, 0);
        end
        step(1, 13, 4, 4, 1);
        check_eq("t3_div_valid", {31'd0, out_valid}, 1);
        check_eq("t3_div_y", 32'(y), 32'h03);
        for (int i = 0; i <= W; i++) step(0, 0, 0, 0, 1);
        check_eq("t3_mod_y", 32'(y), 32'h01);

        // Mod by zero, then a coincident in/out transfer
        step(1, 13, 0, 4, 1);
        step(1, 12, 10, 5, 1);
        check_eq("t4_y", 32'(y), 32'h0D);
        check_eq("t4_dz", {31'd0, dz}, 1);
        step(0, 0, 0, 0, 1);
        check_eq("t4_and_y", 32'(y), 32'h08);
        check_eq("t4_and_dz", {31'd0, dz}, 0);

        // Backpressure holds the result and blocks new input
        step(1, 4'hA, 4'h5, 14, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            check_eq("t5_hold_y", 32'(y), 32'hA5);
            check_eq("t5_blocked", {31'd0, in_ready}, 0);
        end
        step(1, 15, 15, 2, 1);
        check_eq("t5_accept", {31'd0, in_ready}, 1);
        step(0, 0, 0, 0, 1);
        check_eq("t5_mul_y", 32'(y), 32'hE1);

        // Reset two cycles into a divide: the result must never appear
        step(1, 9, 2, 3, 1);
        step(0, 0, 0, 0, 1);
        do_reset();
        for (int i = 0; i < W + 2; i++) step(0, 0, 0, 0, 1);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            op = int'($urandom_range(0, 15));
            av = int'($urandom_range(0, LW));
            bv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, LW));
            step($urandom_range(0, 3) != 0, av, bv, op, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < W + 3; i++) step(0, 0, 0, 0, 1);
        check_eq("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
